video_in_capture: RTL and testbench

Parametrised camera capture engine: frames pixels using LINE_VALID/FRAME_VALID and an in-domain pixel strobe. Packs pixels two per 32-bit word into a FIFO and exposes control, status, data and counters through a 4-word Avalon-MM slave with an interrupt. It sits between the camera input conditioning logic and the NIOS data bus. It supersedes the fixed 12-bit, register-less capture path.

---
 rtl/video_in_pkg.sv | 26 ++
 rtl/video_in_fifo.sv | 51 +++++
 rtl/video_in_capture.sv | 193 +++++++++++++++++++
 tb/tb_video_in_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_in_pkg.sv
// Shared definitions for the camera capture engine: register map, bit positions
// within the control/status registers, and the capture state encoding.
package video_in_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DEC    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_OVF       = 1;
  localparam int STAT_FDONE     = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/video_in_fifo.sv
// Single-clock show-ahead FIFO; a pop and a push in the same cycle both succeed
// even when full, since the pop frees the slot the push needs.
module video_in_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/video_in_capture.sv
// Camera capture engine: frames pixels with LINE/FRAME_VALID, packs two per word
// into a FIFO and exposes control, status, data and counters on an Avalon-MM slave.
module video_in_capture
  import video_in_pkg::*;
#(
  parameter int PIXEL_W    = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic               sys_clk_clk,
  input  logic               sys_reset_reset_n,
  input  logic               video_in_PIXEL_EN,
  input  logic               video_in_LINE_VALID,
  input  logic               video_in_FRAME_VALID,
  input  logic [PIXEL_W-1:0] video_in_PIXEL_DATA,
  input  logic [1:0]         camera_slave_address,
  input  logic               camera_slave_read,
  input  logic               camera_slave_write,
  input  logic [31:0]        camera_slave_writedata,
  output logic [31:0]        camera_slave_readdata,
  output logic               camera_irq
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t state, state_next;
  logic [2:0]       ctrl;
  logic             ovf, fdone;
  logic             lv_q, fv_q;
  logic             half, col_par, line_par;
  logic [15:0]      low_half;
  logic [CNT_W-1:0] line_cnt, frame_cnt, last_lines;

  logic        fv_rise, fv_fall, lv_fall;
  logic        start, done, active;
  logic        col_eff, line_eff, half_eff;
  logic        strobe, accept, flush;
  logic        push, pop, full, empty, overflow;
  logic [31:0] push_word, fifo_rdata, status_word;
  logic [15:0] pixel16;
  logic [LVL_W-1:0] level;
  logic [8:0]  level9;
  logic [7:0]  level8;
  logic        unused_wdata;

  assign fv_rise = video_in_FRAME_VALID & ~fv_q;
  assign fv_fall = ~video_in_FRAME_VALID & fv_q;
  assign lv_fall = ~video_in_LINE_VALID & lv_q;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:
        if (ctrl[CTRL_EN] && !video_in_FRAME_VALID) state_next = ST_ARMED;
      ST_ARMED:
        if (!ctrl[CTRL_EN]) state_next = ST_IDLE;
        else if (fv_rise) begin
          state_next = ST_CAPTURE;
          start      = 1'b1;
        end
      ST_CAPTURE:
        if (fv_fall) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ctrl[CTRL_EN] ? ST_ARMED : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The frame-start cycle already accepts pixels, so parity is seen as cleared there.
  assign active    = start | (state == ST_CAPTURE);
  assign col_eff   = start ? 1'b0 : col_par;
  assign line_eff  = start ? 1'b0 : line_par;
  assign half_eff  = start ? 1'b0 : half;
  assign strobe    = active & video_in_PIXEL_EN & video_in_LINE_VALID & video_in_FRAME_VALID;
  assign accept    = strobe & (~ctrl[CTRL_DEC] | (~col_eff & ~line_eff));
  assign flush     = (state == ST_CAPTURE) & (lv_fall | fv_fall) & half;
  assign pixel16   = 16'(video_in_PIXEL_DATA);
  assign push      = (accept & half_eff) | flush;
  assign push_word = flush ? {16'h0000, low_half} : {pixel16, low_half};
  assign pop       = camera_slave_read & (camera_slave_address == ADDR_DATA) & ~empty;
  assign overflow  = push & full & ~pop;

  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) state <= ST_IDLE;
    else                    state <= state_next;
  end

  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      lv_q       <= 1'b0;
      fv_q       <= 1'b0;
      half       <= 1'b0;
      col_par    <= 1'b0;
      line_par   <= 1'b0;
      low_half   <= '0;
      line_cnt   <= '0;
      frame_cnt  <= '0;
      last_lines <= '0;
    end else begin
      lv_q <= video_in_LINE_VALID;
      fv_q <= video_in_FRAME_VALID;
      if (start) begin
        half     <= 1'b0;
        col_par  <= 1'b0;
        line_par <= 1'b0;
        line_cnt <= '0;
      end
      if (strobe) col_par <= ~col_eff;
      if (accept) begin
        if (!half_eff) begin
          low_half <= pixel16;
          half     <= 1'b1;
        end else begin
          half     <= 1'b0;
        end
      end
      if (state == ST_CAPTURE && lv_fall) begin
        line_cnt <= line_cnt + CNT_W'(1);
        line_par <= ~line_par;
        col_par  <= 1'b0;
        half     <= 1'b0;
      end else if (state == ST_CAPTURE && fv_fall) begin
        half <= 1'b0;
      end
      if (done) begin
        frame_cnt  <= frame_cnt + CNT_W'(1);
        last_lines <= line_cnt;
      end
    end
  end

  video_in_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk_clk),
    .reset_n(sys_reset_reset_n),
    .push   (push),
    .wdata  (push_word),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // A 256-deep FIFO can hold 256 words; the 8-bit level field saturates there.
  assign level9 = 9'(level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  always_comb begin
    status_word                          = '0;
    status_word[STAT_EMPTY]              = empty;
    status_word[STAT_OVF]                = ovf;
    status_word[STAT_FDONE]              = fdone;
    status_word[STAT_LEVEL_LSB +: 8]     = level8;
  end

  assign unused_wdata = &{1'b0, camera_slave_writedata[31:3]};
  assign camera_irq   = ctrl[CTRL_IRQ_EN] & (fdone | ovf);

  // New events win over a same-cycle W1C so none is lost.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      ctrl                  <= '0;
      ovf                   <= 1'b0;
      fdone                 <= 1'b0;
      camera_slave_readdata <= '0;
    end else begin
      if (camera_slave_write && camera_slave_address == ADDR_CTRL)
        ctrl <= camera_slave_writedata[2:0];
      if (camera_slave_write && camera_slave_address == ADDR_STATUS) begin
        if (camera_slave_writedata[STAT_OVF])   ovf   <= 1'b0;
        if (camera_slave_writedata[STAT_FDONE]) fdone <= 1'b0;
      end
      if (overflow) ovf   <= 1'b1;
      if (done)     fdone <= 1'b1;
      if (camera_slave_read) begin
        case (camera_slave_address)
          ADDR_CTRL:   camera_slave_readdata <= {29'd0, ctrl};
          ADDR_STATUS: camera_slave_readdata <= status_word;
          ADDR_DATA:   camera_slave_readdata <= empty ? 32'd0 : fifo_rdata;
          ADDR_COUNT:  camera_slave_readdata <= {16'(frame_cnt), 16'(last_lines)};
          default:     camera_slave_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_in_capture.sv
// Directed bench for video_in_capture with a 4-word FIFO so overflow is easy to reach;
// every expected value below is hand-computed from the register map and pixel values.
module tb_video_in_capture;

  localparam int PIXEL_W = 12;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               pixel_en = 1'b0;
  logic               line_valid = 1'b0;
  logic               frame_valid = 1'b0;
  logic [PIXEL_W-1:0] pixel_data = '0;
  logic [1:0]         address = '0;
  logic               read = 1'b0;
  logic               write = 1'b0;
  logic [31:0]        writedata = '0;
  logic [31:0]        readdata;
  logic               irq;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  video_in_capture #(
    .PIXEL_W(PIXEL_W),
    .FIFO_DEPTH(4),
    .CNT_W(16)
  ) dut (
    .sys_clk_clk           (clk),
    .sys_reset_reset_n     (reset_n),
    .video_in_PIXEL_EN     (pixel_en),
    .video_in_LINE_VALID   (line_valid),
    .video_in_FRAME_VALID  (frame_valid),
    .video_in_PIXEL_DATA   (pixel_data),
    .camera_slave_address  (address),
    .camera_slave_read     (read),
    .camera_slave_write    (write),
    .camera_slave_writedata(writedata),
    .camera_slave_readdata (readdata),
    .camera_irq            (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic lv, input logic pen, input int value);
    @(negedge clk);
    line_valid = lv;
    pixel_en   = pen;
    pixel_data = PIXEL_W'(value);
  endtask

  task automatic send_line(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, base + i * step);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    frame_valid = 1'b0;
    idle(4);
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address   = addr;
    writedata = data;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address = addr;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    data    = readdata;
  endtask

  initial begin
    logic [31:0] rd;

    // Reset state
    idle(3);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(2);
    reg_read(2'd1, rd); checkOutput("reset_status", rd, 32'h0000_0001);
    reg_read(2'd0, rd); checkOutput("reset_ctrl", rd, 32'h0);
    reg_read(2'd3, rd); checkOutput("reset_count", rd, 32'h0);

    // Frame 1: 2 lines x 4 pixels, values 1..8
    reg_write(2'd0, 32'h1);
    idle(3);
    frame_begin();
    send_line(4, 1, 1);
    send_line(4, 5, 1);
    frame_end();
    reg_read(2'd1, rd); checkOutput("f1_status", rd, 32'h0000_0404);
    reg_read(2'd3, rd); checkOutput("f1_count", rd, 32'h0001_0002);
    checkOutput("f1_irq_disabled", {31'd0, irq}, 32'h0);
    reg_read(2'd2, rd); checkOutput("f1_word0", rd, 32'h0002_0001);
    reg_read(2'd2, rd); checkOutput("f1_word1", rd, 32'h0004_0003);
    reg_read(2'd2, rd); checkOutput("f1_word2", rd, 32'h0006_0005);
    reg_read(2'd2, rd); checkOutput("f1_word3", rd, 32'h0008_0007);
    reg_read(2'd2, rd); checkOutput("f1_empty_read", rd, 32'h0);
    reg_read(2'd1, rd); checkOutput("f1_status_empty", rd, 32'h0000_0005);
    reg_write(2'd1, 32'h4);
    reg_read(2'd1, rd); checkOutput("f1_fdone_w1c", rd, 32'h0000_0001);

    // Frame 2: one odd-length line, last pixel flushed alone
    frame_begin();
    send_line(3, 'hA, 1);
    frame_end();
    reg_read(2'd2, rd); checkOutput("f2_word0", rd, 32'h000B_000A);
    reg_read(2'd2, rd); checkOutput("f2_word1", rd, 32'h0000_000C);
    reg_read(2'd3, rd); checkOutput("f2_count", rd, 32'h0002_0001);

    // Frame 3: decimation on a 4x4 frame, pixel = 16*line + col
    reg_write(2'd0, 32'h3);
    frame_begin();
    for (int l = 0; l < 4; l++) send_line(4, 16 * l, 1);
    frame_end();
    reg_read(2'd1, rd); checkOutput("f3_status", rd, 32'h0000_0204);
    reg_read(2'd2, rd); checkOutput("f3_word0", rd, 32'h0002_0000);
    reg_read(2'd2, rd); checkOutput("f3_word1", rd, 32'h0022_0020);
    reg_read(2'd2, rd); checkOutput("f3_empty_read", rd, 32'h0);
    reg_read(2'd3, rd); checkOutput("f3_count", rd, 32'h0003_0004);

    // Frame 4: overflow of the 4-word FIFO, interrupt enabled
    reg_write(2'd1, 32'h6);
    reg_write(2'd0, 32'h5);
    checkOutput("f4_irq_before", {31'd0, irq}, 32'h0);
    frame_begin();
    send_line(12, 1, 1);
    frame_end();
    reg_read(2'd1, rd); checkOutput("f4_status_ovf", rd, 32'h0000_0406);
    checkOutput("f4_irq_set", {31'd0, irq}, 32'h1);
    reg_write(2'd1, 32'h2);
    reg_read(2'd1, rd); checkOutput("f4_ovf_w1c", rd, 32'h0000_0404);
    checkOutput("f4_irq_fdone_only", {31'd0, irq}, 32'h1);
    reg_write(2'd1, 32'h4);
    checkOutput("f4_irq_cleared", {31'd0, irq}, 32'h0);
    reg_read(2'd2, rd); checkOutput("f4_word0", rd, 32'h0002_0001);
    reg_read(2'd2, rd); checkOutput("f4_word1", rd, 32'h0004_0003);
    reg_read(2'd2, rd); checkOutput("f4_word2", rd, 32'h0006_0005);
    reg_read(2'd2, rd); checkOutput("f4_word3", rd, 32'h0008_0007);
    reg_read(2'd2, rd); checkOutput("f4_dropped", rd, 32'h0);

    // EN set mid-frame: that frame is skipped, the next one captured
    reg_write(2'd0, 32'h0);
    idle(2);
    frame_begin();
    send_line(2, 'h21, 1);
    reg_write(2'd0, 32'h1);
    send_line(2, 'h23, 1);
    frame_end();
    reg_read(2'd1, rd); checkOutput("en_mid_skipped", rd, 32'h0000_0001);
    frame_begin();
    send_line(2, 'h31, 1);
    frame_end();
    reg_read(2'd2, rd); checkOutput("en_mid_word", rd, 32'h0032_0031);
    reg_read(2'd3, rd); checkOutput("en_mid_count", rd, 32'h0005_0001);

    // EN cleared mid-frame: current frame completes, next is ignored
    frame_begin();
    send_line(2, 'h41, 1);
    reg_write(2'd0, 32'h0);
    send_line(2, 'h43, 1);
    frame_end();
    frame_begin();
    send_line(2, 'h51, 1);
    frame_end();
    reg_read(2'd2, rd); checkOutput("en_clr_word0", rd, 32'h0042_0041);
    reg_read(2'd2, rd); checkOutput("en_clr_word1", rd, 32'h0044_0043);
    reg_read(2'd2, rd); checkOutput("en_clr_next_ignored", rd, 32'h0);
    reg_read(2'd3, rd); checkOutput("en_clr_count", rd, 32'h0006_0002);

    // Reset in the middle of a capture with data in the FIFO
    reg_write(2'd0, 32'h5);
    idle(2);
    frame_begin();
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 3);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rst_mid_readdata", readdata, 32'h0);
    checkOutput("rst_mid_irq", {31'd0, irq}, 32'h0);
    line_valid  = 1'b0;
    pixel_en    = 1'b0;
    frame_valid = 1'b0;
    reg_read(2'd1, rd); checkOutput("rst_mid_status", rd, 32'h0000_0001);
    reg_read(2'd3, rd); checkOutput("rst_mid_count", rd, 32'h0);
    reg_read(2'd0, rd); checkOutput("rst_mid_ctrl", rd, 32'h0);
    frame_begin();
    send_line(2, 7, 1);
    frame_end();
    reg_read(2'd1, rd); checkOutput("rst_mid_idle", rd, 32'h0000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
